// File: rtl/riscv_bp_pkg.sv
// Shared types and helpers for the in-flight branch tracker.
// No logic; no latency; no flow control.
// Default-configuration entry layout, history shift and taken-bit index.
package riscv_bp_pkg;

  localparam int BP_XLEN_DEF  = 32;
  localparam int BP_GHIST_DEF = 2;
  // Widest history the shift helper supports; callers truncate to their own length.
  localparam int BP_HIST_MAX  = 32;
  localparam int BP_TAKEN_BIT = 1;

  typedef struct packed {
    logic [BP_XLEN_DEF-1:0]  pc;
    logic [BP_GHIST_DEF-1:0] history;
    logic [1:0]              predict;
  } bp_entry_t;

  function automatic logic [BP_HIST_MAX-1:0] bp_hist_shift(
    input logic [BP_HIST_MAX-1:0] hist,
    input logic                   dir
  );
    return BP_HIST_MAX'({hist, dir});
  endfunction

endpackage

// File: rtl/riscv_bp_fifo.sv
// Circular buffer of in-flight branch entries with push, pop and clear.
// Pop data is combinational from the head; updates land on the next edge.
// A push while full is dropped (full sampled before any same-cycle pop); clear wins.
module riscv_bp_fifo
  import riscv_bp_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = bp_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         push_dat,
  input  logic                     pop,
  input  logic                     clear,
  output T                         pop_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  T                 mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // Power-of-two depth: pointer overflow is the wrap.
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear && !rst) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/riscv_bp_track.sv
// Tracks predicted branches from ID until EX resolves them; drives predictor updates.
// Resolve at edge N gives update/mispredict pulse in cycle N+1; history registered.
// id_ready low when DEPTH branches are in flight; flush and mispredict empty the queue.
module riscv_bp_track
  import riscv_bp_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BP_GLOBAL_BITS = 2,
  parameter int DEPTH          = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_bp_push,
  input  logic [XLEN-1:0]           id_pc,
  input  logic [1:0]                id_bp_predict,
  output logic                      id_ready,
  output logic [BP_GLOBAL_BITS-1:0] bp_spec_history,
  input  logic                      ex_resolve,
  input  logic                      ex_btaken,
  input  logic                      ex_flush,
  output logic                      bu_bp_update,
  output logic [XLEN-1:0]           bu_bp_pc,
  output logic [BP_GLOBAL_BITS-1:0] bu_bp_history,
  output logic [1:0]                bu_bp_predict,
  output logic                      bu_bp_btaken,
  output logic                      bu_mispredict
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0]           pc;
    logic [BP_GLOBAL_BITS-1:0] history;
    logic [1:0]                predict;
  } entry_t;

  entry_t                    push_entry;
  entry_t                    head;
  logic [CNT_W-1:0]          count;
  logic                      full;
  logic                      empty;
  logic                      do_pop;
  logic                      do_push;
  logic                      mispred;
  logic                      fifo_clear;
  logic [BP_GLOBAL_BITS-1:0] spec_hist;
  logic [BP_GLOBAL_BITS-1:0] commit_hist;
  logic [BP_GLOBAL_BITS-1:0] spec_next;
  logic [BP_GLOBAL_BITS-1:0] commit_next;

  assign id_ready        = (count != CNT_W'(DEPTH));
  assign bp_spec_history = spec_hist;
  assign push_entry      = '{pc: id_pc, history: spec_hist, predict: id_bp_predict};

  riscv_bp_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (do_push),
    .push_dat (push_entry),
    .pop      (do_pop),
    .clear    (fifo_clear),
    .pop_dat  (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    do_pop      = ex_resolve && !empty && !ex_flush;
    mispred     = do_pop && (head.predict[BP_TAKEN_BIT] != ex_btaken);
    // A mispredict kills the younger, wrong-path push in the same cycle.
    do_push     = id_bp_push && !full && !ex_flush && !mispred;
    fifo_clear  = ex_flush || mispred;

    commit_next = commit_hist;
    if (do_pop)
      commit_next = BP_GLOBAL_BITS'(bp_hist_shift(BP_HIST_MAX'(commit_hist), ex_btaken));

    spec_next = spec_hist;
    if (ex_flush)
      spec_next = commit_hist;
    else if (mispred)
      spec_next = commit_next;
    else if (do_push)
      spec_next = BP_GLOBAL_BITS'(bp_hist_shift(BP_HIST_MAX'(spec_hist),
                                                id_bp_predict[BP_TAKEN_BIT]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spec_hist   <= '0;
      commit_hist <= '0;
    end else begin
      spec_hist   <= spec_next;
      commit_hist <= commit_next;
    end
  end

  // Update data is held between pulses so the predictor can sample it late.
  always_ff @(posedge clk) begin
    if (rst) begin
      bu_bp_update  <= 1'b0;
      bu_mispredict <= 1'b0;
      bu_bp_pc      <= '0;
      bu_bp_history <= '0;
      bu_bp_predict <= '0;
      bu_bp_btaken  <= 1'b0;
    end else begin
      bu_bp_update  <= do_pop;
      bu_mispredict <= mispred;
      if (do_pop) begin
        bu_bp_pc      <= head.pc;
        bu_bp_history <= head.history;
        bu_bp_predict <= head.predict;
        bu_bp_btaken  <= ex_btaken;
      end
    end
  end

endmodule

// File: tb/tb_riscv_bp_track.sv
// Self-checking bench for riscv_bp_track: directed scenarios plus a random run
// checked against a queue-based reference model.
module tb_riscv_bp_track;

  localparam int XLEN  = 32;
  localparam int G     = 2;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_bp_push;
  logic [XLEN-1:0] id_pc;
  logic [1:0]      id_bp_predict;
  logic            id_ready;
  logic [G-1:0]    bp_spec_history;
  logic            ex_resolve;
  logic            ex_btaken;
  logic            ex_flush;
  logic            bu_bp_update;
  logic [XLEN-1:0] bu_bp_pc;
  logic [G-1:0]    bu_bp_history;
  logic [1:0]      bu_bp_predict;
  logic            bu_bp_btaken;
  logic            bu_mispredict;

  int checks   = 0;
  int failures = 0;

  riscv_bp_track #(.XLEN(XLEN), .BP_GLOBAL_BITS(G), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_bp_push      (id_bp_push),
    .id_pc           (id_pc),
    .id_bp_predict   (id_bp_predict),
    .id_ready        (id_ready),
    .bp_spec_history (bp_spec_history),
    .ex_resolve      (ex_resolve),
    .ex_btaken       (ex_btaken),
    .ex_flush        (ex_flush),
    .bu_bp_update    (bu_bp_update),
    .bu_bp_pc        (bu_bp_pc),
    .bu_bp_history   (bu_bp_history),
    .bu_bp_predict   (bu_bp_predict),
    .bu_bp_btaken    (bu_bp_btaken),
    .bu_mispredict   (bu_mispredict)
  );

  always #5 clk = ~clk;

  // Reference model: list of in-flight branches plus the two histories.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [G-1:0]    hist;
    logic [1:0]      pred;
  } ent_t;

  ent_t            mq[$];
  logic [G-1:0]    m_spec, m_commit;
  logic            m_upd, m_mis, m_bt;
  logic [XLEN-1:0] m_pc;
  logic [G-1:0]    m_hist;
  logic [1:0]      m_pred;

  task automatic model_reset();
    mq.delete();
    m_spec = '0; m_commit = '0;
    m_upd = 1'b0; m_mis = 1'b0; m_bt = 1'b0;
    m_pc = '0; m_hist = '0; m_pred = '0;
  endtask

  task automatic model_step(input logic push, input logic [XLEN-1:0] pc, input logic [1:0] pred,
                            input logic res, input logic bt, input logic fl);
    bit   ready;
    bit   mis;
    ent_t e;
    ready = (mq.size() < DEPTH);
    mis   = 1'b0;
    m_upd = 1'b0;
    m_mis = 1'b0;
    if (fl) begin
      mq.delete();
      m_spec = m_commit;
    end else begin
      if (res && mq.size() > 0) begin
        e = mq.pop_front();
        m_commit = {m_commit[G-2:0], bt};
        m_upd  = 1'b1;
        m_pc   = e.pc;
        m_hist = e.hist;
        m_pred = e.pred;
        m_bt   = bt;
        mis    = (e.pred[1] != bt);
        m_mis  = mis;
      end
      if (mis) begin
        mq.delete();
        m_spec = m_commit;
      end else if (push && ready) begin
        e.pc = pc; e.hist = m_spec; e.pred = pred;
        mq.push_back(e);
        m_spec = {m_spec[G-2:0], pred[1]};
      end
    end
  endtask

  task automatic drive(input logic push, input logic [XLEN-1:0] pc, input logic [1:0] pred,
                       input logic res, input logic bt, input logic fl);
    id_bp_push = push; id_pc = pc; id_bp_predict = pred;
    ex_resolve = res; ex_btaken = bt; ex_flush = fl;
    model_step(push, pc, pred, res, bt, fl);
    @(posedge clk); #1;
    id_bp_push = 1'b0; id_pc = '0; id_bp_predict = '0;
    ex_resolve = 1'b0; ex_btaken = 1'b0; ex_flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    id_bp_push = 1'b0; id_pc = '0; id_bp_predict = '0;
    ex_resolve = 1'b0; ex_btaken = 1'b0; ex_flush = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", id_ready); end
    checks++; if (bp_spec_history !== 2'b00) begin failures++; $display("FAIL reset_spec got=%b exp=00", bp_spec_history); end
    checks++; if (bu_bp_update !== 1'b0) begin failures++; $display("FAIL reset_update got=%0b exp=0", bu_bp_update); end
    checks++; if (bu_mispredict !== 1'b0) begin failures++; $display("FAIL reset_mispredict got=%0b exp=0", bu_mispredict); end
    checks++; if ({bu_bp_pc, bu_bp_history, bu_bp_predict, bu_bp_btaken} !== '0) begin
      failures++; $display("FAIL reset_bu_data got=%h/%b/%b/%b exp=0", bu_bp_pc, bu_bp_history, bu_bp_predict, bu_bp_btaken);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 2'b10, 1'b0, 1'b0, 1'b0);
      if (i == 0) begin
        checks++; if (bp_spec_history !== 2'b01) begin failures++; $display("FAIL fill_spec_first got=%b exp=01", bp_spec_history); end
      end
    end
    checks++; if (bp_spec_history !== 2'b11) begin failures++; $display("FAIL fill_spec got=%b exp=11", bp_spec_history); end
    checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL fill_full_ready got=%0b exp=0", id_ready); end
    drive(1'b1, 32'h210, 2'b00, 1'b0, 1'b0, 1'b0);
    checks++; if (bp_spec_history !== 2'b11) begin failures++; $display("FAIL fill_drop_spec got=%b exp=11", bp_spec_history); end
    checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL fill_drop_ready got=%0b exp=0", id_ready); end
  endtask

  task automatic test_resolve_taken();
    drive(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b0);
    checks++; if (bu_bp_update !== 1'b1) begin failures++; $display("FAIL resolve_update got=%0b exp=1", bu_bp_update); end
    checks++; if (bu_bp_pc !== 32'h200) begin failures++; $display("FAIL resolve_pc got=%h exp=00000200", bu_bp_pc); end
    checks++; if (bu_bp_history !== 2'b00) begin failures++; $display("FAIL resolve_hist got=%b exp=00", bu_bp_history); end
    checks++; if (bu_bp_predict !== 2'b10) begin failures++; $display("FAIL resolve_pred got=%b exp=10", bu_bp_predict); end
    checks++; if (bu_bp_btaken !== 1'b1) begin failures++; $display("FAIL resolve_btaken got=%0b exp=1", bu_bp_btaken); end
    checks++; if (bu_mispredict !== 1'b0) begin failures++; $display("FAIL resolve_mispredict got=%0b exp=0", bu_mispredict); end
    checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL resolve_ready got=%0b exp=1", id_ready); end
    drive(1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
    checks++; if (bu_bp_update !== 1'b0) begin failures++; $display("FAIL resolve_pulse_end got=%0b exp=0", bu_bp_update); end
    checks++; if (bu_bp_pc !== 32'h200) begin failures++; $display("FAIL resolve_pc_held got=%h exp=00000200", bu_bp_pc); end
    // Second oldest carries the history snapshot taken after one push.
    drive(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b0);
    checks++; if (bu_bp_pc !== 32'h204 || bu_bp_history !== 2'b01) begin
      failures++; $display("FAIL resolve_second got=%h/%b exp=00000204/01", bu_bp_pc, bu_bp_history);
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h300 + 32'(4 * i), 2'b10, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h30C, 2'b10, 1'b1, 1'b0, 1'b0);
    checks++; if (bu_mispredict !== 1'b1 || bu_bp_update !== 1'b1) begin
      failures++; $display("FAIL mis_pulse got=mis%0b/upd%0b exp=1/1", bu_mispredict, bu_bp_update);
    end
    checks++; if (bu_bp_pc !== 32'h300) begin failures++; $display("FAIL mis_pc got=%h exp=00000300", bu_bp_pc); end
    checks++; if (bp_spec_history !== 2'b00) begin failures++; $display("FAIL mis_spec got=%b exp=00", bp_spec_history); end
    checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL mis_ready got=%0b exp=1", id_ready); end
    drive(1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
    checks++; if (bu_mispredict !== 1'b0) begin failures++; $display("FAIL mis_pulse_end got=%0b exp=0", bu_mispredict); end
  endtask

  task automatic test_empty_resolve();
    drive(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b0);
    checks++; if (bu_bp_update !== 1'b0) begin failures++; $display("FAIL empty_update got=%0b exp=0", bu_bp_update); end
    checks++; if (bp_spec_history !== 2'b00) begin failures++; $display("FAIL empty_spec got=%b exp=00", bp_spec_history); end
    // Committed history is observed through a flush.
    drive(1'b1, 32'h3F0, 2'b10, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b1);
    checks++; if (bp_spec_history !== 2'b00) begin failures++; $display("FAIL empty_commit got=%b exp=00", bp_spec_history); end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h400, 2'b10, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h404, 2'b00, 1'b0, 1'b0, 1'b0);
    checks++; if (bp_spec_history !== 2'b10) begin failures++; $display("FAIL flush_pre_spec got=%b exp=10", bp_spec_history); end
    drive(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 32'h408, 2'b10, 1'b1, 1'b0, 1'b1);
    checks++; if (bu_bp_update !== 1'b0 || bu_mispredict !== 1'b0) begin
      failures++; $display("FAIL flush_no_update got=upd%0b/mis%0b exp=0/0", bu_bp_update, bu_mispredict);
    end
    checks++; if (bp_spec_history !== 2'b01) begin failures++; $display("FAIL flush_spec got=%b exp=01", bp_spec_history); end
    drive(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b0);
    checks++; if (bu_bp_update !== 1'b0) begin failures++; $display("FAIL flush_empty got=%0b exp=0", bu_bp_update); end
  endtask

  task automatic test_full_push_resolve();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h500 + 32'(4 * i), 2'b10, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h5F0, 2'b10, 1'b1, 1'b1, 1'b0);
    checks++; if (bu_bp_update !== 1'b1 || bu_bp_pc !== 32'h500) begin
      failures++; $display("FAIL full_pop got=upd%0b/%h exp=1/00000500", bu_bp_update, bu_bp_pc);
    end
    checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL full_drop_ready got=%0b exp=1", id_ready); end
    for (int i = 0; i < 3 * DEPTH; i++) begin
      drive(1'b1, 32'h600 + 32'(4 * i), 2'b10, 1'b1, 1'b1, 1'b0);
      checks++; if (bu_bp_update !== 1'b1 || bu_bp_pc !== m_pc || id_ready !== 1'b1) begin
        failures++; $display("FAIL wrap_%0d got=upd%0b/%h/rdy%0b exp=1/%h/1", i, bu_bp_update, bu_bp_pc, id_ready, m_pc);
      end
    end
  endtask

  task automatic test_random();
    logic            push, res, bt, fl;
    logic [1:0]      pred;
    logic [XLEN-1:0] pc;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      push = ($urandom_range(2) != 0);
      pred = 2'($urandom);
      pc   = {$urandom, 2'b00} >> 2 << 2;
      res  = ($urandom_range(1) != 0);
      fl   = ($urandom_range(39) == 0);
      bt   = (mq.size() > 0 && $urandom_range(4) != 0) ? mq[0].pred[1] : 1'($urandom);
      checks++; if (id_ready !== (mq.size() < DEPTH)) begin
        failures++; $display("FAIL rand_ready_%0d got=%0b exp=%0b", i, id_ready, (mq.size() < DEPTH));
      end
      drive(push, pc, pred, res, bt, fl);
      checks++;
      if ({bu_bp_update, bu_mispredict, bu_bp_pc, bu_bp_history, bu_bp_predict, bu_bp_btaken, bp_spec_history}
          !== {m_upd, m_mis, m_pc, m_hist, m_pred, m_bt, m_spec}) begin
        failures++;
        $display("FAIL rand_out_%0d got=upd%0b mis%0b pc%h h%b p%b bt%0b spec%b exp=upd%0b mis%0b pc%h h%b p%b bt%0b spec%b",
                 i, bu_bp_update, bu_mispredict, bu_bp_pc, bu_bp_history, bu_bp_predict, bu_bp_btaken, bp_spec_history,
                 m_upd, m_mis, m_pc, m_hist, m_pred, m_bt, m_spec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_resolve_taken();
    test_mispredict();
    test_empty_resolve();
    test_flush();
    test_full_push_resolve();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
